inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit: the reader side of the instruction memory. It owns the program counter, drives the byte address into the combinationally-read instruction memory, and captures each returned word with its PC into a 2-entry buffer. It presents fetched instructions to decode over a valid/ready handshake and accepts PC redirects from the branch unit. It sits between the instruction memory and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_addr  output  32  byte address to the instruction memory; equals the PC register.
- imem_instr  input  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  input  1  load a new PC this cycle.
- redirect_pc  input  32  target PC; bits [1:0] are forced to 0.
- out_valid  output  1  buffer head holds an instruction.
- out_instr  output  32  instruction at buffer head.
- out_pc  output  32  PC of out_instr.
- out_ready  input  1  decode accepts the head this cycle.

## Operation
- State: pc (32b), 2-entry buffer of {pc, instr}, count (0..2).
- pop = out_valid & out_ready.
- fetch = (count < 2) | pop, evaluated without redirect.
- Normal cycle with fetch: push {pc, imem_instr}; pc <= pc + PC_STEP (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- No fetch (full, no pop): pc holds, no push, imem_addr stable.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Redirect (priority over everything): pc <= {redirect_pc[31:2], 2'b00}; all buffer entries discarded, count <= 0; no push that cycle. A handshake (pop) completing in the redirect cycle is a completed transfer for decode; the unit does not re-present it.
- Instruction words are passed through unmodified; all-zero words (NOP) are buffered like any other.
- Reset (rst low, any time, including mid-stream or mid-redirect): pc <= RESET_PC, count <= 0; buffer contents are don't-care.

## Timing
- Reset values: imem_addr = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0.
- Latency: instruction at address A presented on imem_addr in cycle N appears on out_valid/out_instr/out_pc in cycle N+1.
- First cycle after reset release: imem_addr = RESET_PC; out_valid = 1 from the following cycle.
- Throughput: 1 instruction/cycle while out_ready = 1.
- Backpressure: with out_ready = 0, at most 2 instructions are buffered, then fetch stops. pc then points to the next unfetched address.
- Redirect in cycle N: out_valid = 0 in cycle N+1; imem_addr = target in N+1; target instruction is valid in N+2.
- out_valid, out_instr, and out_pc are driven only from registers. There is no combinational path from out_ready or redirect_valid to any output.

## Structure
- Shared package `fetch_pkg` contains: RESET_PC default, PC_STEP, NOP word 32'h0000_0000, and a packed struct `fetch_entry_t` {pc[31:0], instr[31:0]}.
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, full, empty. inst_fetch holds the pc register and fetch/redirect control around it.

## Test plan
- Reset and stream: hold rst low, then release with out_ready = 1 and memory words 0, 0x00...33 at 4, … -> out_pc sequence 0, 4, 8, 12 on consecutive cycles from the second cycle after release, with out_instr matching the memory.
- Backpressure: out_ready = 0 for 5 cycles after start -> count saturates at 2 (pc 0, 4 buffered), imem_addr holds at 8. Release -> outputs 0, 4, 8 in order with no loss or duplicate.
- Redirect: redirect_valid = 1 with redirect_pc = 0x28 while 2 entries are buffered -> next cycle out_valid = 0 and imem_addr = 0x28; the cycle after that, out_pc = 0x28 and out_instr = word at 40.
- Misaligned redirect with simultaneous pop: redirect_pc = 0x1E while out_ready = 1 -> pc loads 0x1C, the popped entry counts as consumed, and no stale PC appears afterward.
- Wrap: RESET_PC = 32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Mid-operation reset: pull rst low asynchronously (between edges) while streaming -> out_valid drops to 0 immediately and imem_addr = RESET_PC. After release, the stream restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the buffered fetch record used by the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_BYTES    = 32'd4;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetch records. Entry 0 is always the head, so the head
// leaves straight from a register with no read-pointer mux.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;
    logic         do_push;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign count   = count_q;
    assign head    = e0_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) e0_d = din;
                    else                 e1_d = din;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Head leaves and the new word lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        e0_d = din;
                    end else begin
                        e0_d = e1_q;
                        e1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0_q    <= '{pc: 32'h0, instr: NOP_WORD};
            e1_q    <= '{pc: 32'h0, instr: NOP_WORD};
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory
// and buffers {pc, instr} for decode; redirects flush the buffer and reload the PC.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    logic [31:0]  pc_q, pc_d;
    logic         pop;
    logic         fetch;
    logic         push;
    fetch_entry_t fifo_head;
    logic [1:0]   fifo_count;
    logic         fifo_full;
    logic         fifo_empty;

    // Handshake: decode takes the head on any cycle where out_valid and
    // out_ready are both high, including a redirect cycle.
    assign pop       = out_valid & out_ready;
    assign fetch     = ~fifo_full | pop;
    assign push      = fetch & ~redirect_valid;
    assign imem_addr = pc_q;
    assign out_valid = ~fifo_empty;
    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc & ~32'h3;
        else if (fetch)     pc_d = pc_q + PC_STEP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ('{pc: pc_q, instr: imem_instr}),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    a_count_range: assert property (@(posedge clk) disable iff (!rst) fifo_count != 2'd3);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr, out_pc;
    logic        out_ready;

    logic        rst_w;
    logic [31:0] imem_addr_w, imem_instr_w;
    logic        out_valid_w;
    logic [31:0] out_instr_w, out_pc_w;

    int n_vec  = 0;
    int n_fail = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0;
        if (a == 32'h4) return 32'h33;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_instr   = mem_word(imem_addr);
    assign imem_instr_w = mem_word(imem_addr_w);

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk            (clk),
        .rst            (rst_w),
        .imem_addr      (imem_addr_w),
        .imem_instr     (imem_instr_w),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .out_valid      (out_valid_w),
        .out_instr      (out_instr_w),
        .out_pc         (out_pc_w),
        .out_ready      (1'b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: exp_q holds {pc, instr} of buffered instructions.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_pop, m_room;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_pc = 32'h0;
        end else begin
            m_pop  = out_ready && (exp_q.size() > 0);
            m_room = (exp_q.size() < 2) || m_pop;
            if (redirect_valid) begin
                exp_q.delete();
                m_pc = redirect_pc & ~32'h3;
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (m_room) begin
                    exp_q.push_back({m_pc, mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("model_imem_addr", imem_addr, m_pc);
            check("model_out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                check("model_out_pc", out_pc, exp_q[0][63:32]);
                check("model_out_instr", out_instr, exp_q[0][31:0]);
            end
        end
    end

    initial begin
        rst = 1'b0; rst_w = 1'b0;
        out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        run_cmp = 1'b1;
        step(3);
        check("reset_addr", imem_addr, 32'h0);
        check("reset_valid", {31'b0, out_valid}, 32'h0);
        check("reset_instr", out_instr, 32'h0);
        check("reset_pc", out_pc, 32'h0);

        // Stream from reset
        rst = 1'b1;
        check("first_addr", imem_addr, 32'h0);
        check("first_valid", {31'b0, out_valid}, 32'h0);
        step; check("stream_pc0", out_pc, 32'h0); check("stream_nop", out_instr, 32'h0);
        check("stream_valid", {31'b0, out_valid}, 32'h1);
        step; check("stream_pc4", out_pc, 32'h4); check("stream_instr4", out_instr, 32'h33);
        step; check("stream_pc8", out_pc, 32'h8);
        step; check("stream_pc12", out_pc, 32'hC);

        // Backpressure from start
        rst = 1'b0; step; out_ready = 1'b0; rst = 1'b1;
        step(5);
        check("bp_addr_hold", imem_addr, 32'h8);
        check("bp_head", out_pc, 32'h0);
        out_ready = 1'b1;
        step; check("bp_rel_pc4", out_pc, 32'h4);
        step; check("bp_rel_pc8", out_pc, 32'h8);
        step; check("bp_rel_pc12", out_pc, 32'hC);

        // Redirect while full
        out_ready = 1'b0; step(3);
        redirect_valid = 1'b1; redirect_pc = 32'h28;
        step; redirect_valid = 1'b0;
        check("redir_valid0", {31'b0, out_valid}, 32'h0);
        check("redir_addr", imem_addr, 32'h28);
        step; check("redir_pc", out_pc, 32'h28);
        check("redir_instr", out_instr, 32'hA5A5_0028);
        step;

        // Misaligned redirect with pop in the same cycle
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1E;
        step; redirect_valid = 1'b0;
        check("mis_addr", imem_addr, 32'h1C);
        check("mis_valid0", {31'b0, out_valid}, 32'h0);
        step; check("mis_pc", out_pc, 32'h1C); check("mis_instr", out_instr, 32'hA5A5_001C);
        step; check("mis_next", out_pc, 32'h20);

        // Asynchronous reset mid-stream
        step(2); #3; rst = 1'b0; #1;
        check("async_valid", {31'b0, out_valid}, 32'h0);
        check("async_addr", imem_addr, 32'h0);
        step(2); rst = 1'b1;
        check("restart_addr", imem_addr, 32'h0);
        step; check("restart_pc0", out_pc, 32'h0);
        step; check("restart_pc4", out_pc, 32'h4);

        // PC wrap on second instance
        rst_w = 1'b1;
        step; check("wrap_pc_f8", out_pc_w, 32'hFFFF_FFF8);
        check("wrap_instr_f8", out_instr_w, 32'h5A5A_FFF8);
        step; check("wrap_pc_fc", out_pc_w, 32'hFFFF_FFFC);
        check("wrap_addr0", imem_addr_w, 32'h0);
        step; check("wrap_pc_0", out_pc_w, 32'h0);
        check("wrap_valid", {31'b0, out_valid_w}, 32'h1);

        run_cmp = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
